// File: rtl/cmd_arbiter_pkg.sv
// Shared main-core command header: serial command field widths and the arbiter
// state encoding, whose bits double as the one-hot grant vector.
package cmd_arbiter_pkg;

    localparam int unsigned MainCoreCmdWhichSize  = 2;
    localparam int unsigned MainCoreSerialCmdSize = 6;
    localparam int unsigned MainCoreCmdSize       = MainCoreCmdWhichSize + MainCoreSerialCmdSize;

    // Bit i set means requester i owns the core; StIdle drives grant = 2'b00.
    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StGrant0 = 2'b01,
        StGrant1 = 2'b10
    } arb_state_e;

    function automatic arb_state_e grant_state(input logic idx);
        return idx ? StGrant1 : StGrant0;
    endfunction

endpackage

// File: rtl/cmd_arbiter_fifo.sv
// Per-requester command queue with a registered occupancy count; push uses an
// isReady/canReceive handshake, the read side exposes head/hasAny and a pop strobe.
module cmd_arbiter_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         data,
    input  logic                     isReady,
    output logic                     canReceive,
    input  logic                     pop,
    output logic                     hasAny,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             push_en;
    logic             pop_en;

    // Full/empty come from the registered count only, so a same-cycle pop never
    // reopens a full queue to a push.
    assign canReceive = (count_q < (PtrW + 1)'(DEPTH));
    assign hasAny     = (count_q != '0);
    assign push_en    = isReady & canReceive;
    assign pop_en     = pop & hasAny;
    assign head       = mem_q[rd_ptr_q];
    assign count      = count_q;

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cmd_arbiter.sv
// Two-requester round-robin arbiter in front of main_core_serialCmd, with an
// optional per-command lock that keeps the grant across consecutive commands.
module cmd_arbiter
    import cmd_arbiter_pkg::*;
#(
    parameter int unsigned CMD_W = MainCoreCmdSize,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CMD_W-1:0] rq0_cmd,
    input  logic             rq0_lock,
    input  logic             rq0_isReady,
    output logic             rq0_canReceive,
    input  logic [CMD_W-1:0] rq1_cmd,
    input  logic             rq1_lock,
    input  logic             rq1_isReady,
    output logic             rq1_canReceive,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_hasAny,
    input  logic             cmd_consume,
    output logic [1:0]       grant
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    // Queue entries are {lock, cmd}.
    logic [CMD_W:0]  q0_head,  q1_head;
    logic            q0_has,   q1_has;
    logic            q0_can,   q1_can;
    logic            q0_pop,   q1_pop;
    logic [CntW-1:0] q0_count, q1_count;

    arb_state_e state_q, state_d;
    logic       rr_q, rr_d;

    logic            owner_idx;
    logic            own_has;
    logic            own_push;
    logic            other_has;
    logic [CMD_W:0]  own_head;
    logic [CntW-1:0] own_count;
    logic            own_keeps;
    logic            pop_fire;

    cmd_arbiter_fifo #(
        .WIDTH (CMD_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk        (clk),
        .rst        (rst),
        .data       ({rq0_lock, rq0_cmd}),
        .isReady    (rq0_isReady),
        .canReceive (q0_can),
        .pop        (q0_pop),
        .hasAny     (q0_has),
        .head       (q0_head),
        .count      (q0_count)
    );

    cmd_arbiter_fifo #(
        .WIDTH (CMD_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk        (clk),
        .rst        (rst),
        .data       ({rq1_lock, rq1_cmd}),
        .isReady    (rq1_isReady),
        .canReceive (q1_can),
        .pop        (q1_pop),
        .hasAny     (q1_has),
        .head       (q1_head),
        .count      (q1_count)
    );

    always_comb begin
        owner_idx = 1'b0;
        own_has   = 1'b0;
        own_head  = '0;
        own_count = '0;
        own_push  = 1'b0;
        other_has = 1'b0;
        unique case (state_q)
            StGrant0: begin
                own_has   = q0_has;
                own_head  = q0_head;
                own_count = q0_count;
                own_push  = rq0_isReady & q0_can;
                other_has = q1_has;
            end
            StGrant1: begin
                owner_idx = 1'b1;
                own_has   = q1_has;
                own_head  = q1_head;
                own_count = q1_count;
                own_push  = rq1_isReady & q1_can;
                other_has = q0_has;
            end
            default: ;
        endcase
    end

    assign pop_fire = cmd_consume & own_has;
    assign q0_pop   = pop_fire & (state_q == StGrant0);
    assign q1_pop   = pop_fire & (state_q == StGrant1);
    // Owner queue still non-empty after this edge: more than one entry, or a refill now.
    assign own_keeps = (own_count[CntW-1:1] != '0) | own_push;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        unique case (state_q)
            StIdle: begin
                if (q0_has && q1_has) begin
                    state_d = grant_state(rr_q);
                end else if (q0_has) begin
                    state_d = StGrant0;
                end else if (q1_has) begin
                    state_d = StGrant1;
                end
            end
            StGrant0, StGrant1: begin
                // A locked entry leaves the grant untouched, even on an emptied queue.
                if (pop_fire && !own_head[CMD_W]) begin
                    rr_d = ~owner_idx;
                    if (other_has) begin
                        state_d = grant_state(~owner_idx);
                    end else if (!own_keeps) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    // Outputs are forced to their idle values while rst is asserted.
    assign cmd_hasAny     = own_has & ~rst;
    assign cmd            = cmd_hasAny ? own_head[CMD_W-1:0] : '0;
    assign grant          = rst ? 2'b00 : state_q;
    assign rq0_canReceive = rst | q0_can;
    assign rq1_canReceive = rst | q1_can;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Self-checking bench for cmd_arbiter: directed vector table, hand sequences for
// alternation, lock hold and mid-stream reset, then random traffic against a queue model.
module tb_cmd_arbiter;
    import cmd_arbiter_pkg::*;

    localparam int unsigned W = MainCoreCmdSize;
    localparam int unsigned D = 4;

    typedef logic [W:0] ent_t;

    typedef struct {
        bit           rst;
        bit           r0;
        logic [W-1:0] c0;
        bit           l0;
        bit           r1;
        logic [W-1:0] c1;
        bit           l1;
        bit           cons;
        bit           e_can0;
        bit           e_can1;
        bit           e_has;
        logic [W-1:0] e_cmd;
        logic [1:0]   e_grant;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] rq0_cmd, rq1_cmd;
    logic         rq0_lock, rq1_lock;
    logic         rq0_isReady, rq1_isReady;
    logic         rq0_canReceive, rq1_canReceive;
    logic [W-1:0] cmd;
    logic         cmd_hasAny;
    logic         cmd_consume;
    logic [1:0]   grant;

    cmd_arbiter #(
        .CMD_W (W),
        .DEPTH (D)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rq0_cmd        (rq0_cmd),
        .rq0_lock       (rq0_lock),
        .rq0_isReady    (rq0_isReady),
        .rq0_canReceive (rq0_canReceive),
        .rq1_cmd        (rq1_cmd),
        .rq1_lock       (rq1_lock),
        .rq1_isReady    (rq1_isReady),
        .rq1_canReceive (rq1_canReceive),
        .cmd            (cmd),
        .cmd_hasAny     (cmd_hasAny),
        .cmd_consume    (cmd_consume),
        .grant          (grant)
    );

    always #5 clk = ~clk;

    // Reference model: plain queues, owner number (0 idle, 1 rq0, 2 rq1), rr favourite.
    ent_t         mq0[$];
    ent_t         mq1[$];
    int           m_state = 0;
    bit           m_rr = 1'b0;
    logic [W-1:0] got[$];
    int           exp_q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    vec_t         vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_has();
        if (m_state == 1) return mq0.size() > 0;
        if (m_state == 2) return mq1.size() > 0;
        return 1'b0;
    endfunction

    task automatic model_check();
        bit         h;
        ent_t       hd;
        logic [1:0] g;
        h  = !rst && m_has();
        hd = '0;
        if (h) hd = (m_state == 1) ? mq0[0] : mq1[0];
        g = rst ? 2'b00 : (m_state == 1 ? 2'b01 : (m_state == 2 ? 2'b10 : 2'b00));
        chk("can0", rq0_canReceive, rst || mq0.size() < D);
        chk("can1", rq1_canReceive, rst || mq1.size() < D);
        chk("hasAny", cmd_hasAny, h);
        chk("cmd", cmd, hd[W-1:0]);
        chk("grant", grant, g);
    endtask

    task automatic model_step();
        int   s0, s1, own_after, other_size;
        bit   h, pop, p0, p1;
        ent_t popped;
        if (rst) begin
            mq0.delete();
            mq1.delete();
            m_state = 0;
            m_rr    = 1'b0;
            return;
        end
        s0     = mq0.size();
        s1     = mq1.size();
        h      = m_has();
        pop    = cmd_consume && h;
        p0     = rq0_isReady && s0 < D;
        p1     = rq1_isReady && s1 < D;
        popped = '0;
        if (pop) begin
            popped = (m_state == 1) ? mq0.pop_front() : mq1.pop_front();
            got.push_back(popped[W-1:0]);
        end
        if (p0) mq0.push_back({rq0_lock, rq0_cmd});
        if (p1) mq1.push_back({rq1_lock, rq1_cmd});
        if (m_state == 0) begin
            if (s0 > 0 && s1 > 0) m_state = m_rr ? 2 : 1;
            else if (s0 > 0)      m_state = 1;
            else if (s1 > 0)      m_state = 2;
        end else if (pop && !popped[W]) begin
            other_size = (m_state == 1) ? s1 : s0;
            own_after  = (m_state == 1) ? mq0.size() : mq1.size();
            m_rr       = (m_state == 1);
            if (other_size > 0)      m_state = 3 - m_state;
            else if (own_after == 0) m_state = 0;
        end
    endtask

    task automatic half_check();
        @(negedge clk);
        model_check();
    endtask

    task automatic half_edge();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cycle();
        half_check();
        half_edge();
    endtask

    task automatic drive(input bit r0, input int c0, input bit l0,
                         input bit r1, input int c1, input bit l1, input bit cons);
        rq0_isReady = r0;
        rq0_cmd     = c0[W-1:0];
        rq0_lock    = l0;
        rq1_isReady = r1;
        rq1_cmd     = c1[W-1:0];
        rq1_lock    = l1;
        cmd_consume = cons;
    endtask

    task automatic chk_order(input string name);
        chk({name, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk(name, got[i], exp_q[i]);
        end
        got.delete();
        exp_q.delete();
    endtask

    function automatic vec_t mk(input bit rs, input bit r0, input int c0, input bit r1,
                                input int c1, input bit cons, input bit e0, input bit e1,
                                input bit eh, input int ec, input int eg);
        vec_t v;
        v.rst = rs;    v.r0 = r0;   v.c0 = c0[W-1:0]; v.l0 = 1'b0;
        v.r1 = r1;     v.c1 = c1[W-1:0]; v.l1 = 1'b0;  v.cons = cons;
        v.e_can0 = e0; v.e_can1 = e1; v.e_has = eh;
        v.e_cmd = ec[W-1:0]; v.e_grant = eg[1:0];
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);

        // Single push/consume, then fill rq1 past full, drain, spurious consume.
        vecs[0]  = mk(1, 0, 0,    0, 0,    0, 1, 1, 0, 0,    0);
        vecs[1]  = mk(0, 1, 'h15, 0, 0,    0, 1, 1, 0, 0,    0);
        vecs[2]  = mk(0, 0, 0,    0, 0,    0, 1, 1, 0, 0,    0);
        vecs[3]  = mk(0, 0, 0,    0, 0,    1, 1, 1, 1, 'h15, 1);
        vecs[4]  = mk(0, 0, 0,    0, 0,    0, 1, 1, 0, 0,    0);
        vecs[5]  = mk(0, 0, 0,    1, 'h31, 0, 1, 1, 0, 0,    0);
        vecs[6]  = mk(0, 0, 0,    1, 'h32, 0, 1, 1, 0, 0,    0);
        vecs[7]  = mk(0, 0, 0,    1, 'h33, 0, 1, 1, 1, 'h31, 2);
        vecs[8]  = mk(0, 0, 0,    1, 'h34, 0, 1, 1, 1, 'h31, 2);
        vecs[9]  = mk(0, 0, 0,    1, 'h35, 0, 1, 0, 1, 'h31, 2);
        vecs[10] = mk(0, 0, 0,    0, 0,    1, 1, 0, 1, 'h31, 2);
        vecs[11] = mk(0, 0, 0,    0, 0,    1, 1, 1, 1, 'h32, 2);
        vecs[12] = mk(0, 0, 0,    0, 0,    1, 1, 1, 1, 'h33, 2);
        vecs[13] = mk(0, 0, 0,    0, 0,    1, 1, 1, 1, 'h34, 2);
        vecs[14] = mk(0, 0, 0,    0, 0,    0, 1, 1, 0, 0,    0);
        vecs[15] = mk(0, 0, 0,    0, 0,    1, 1, 1, 0, 0,    0);
        vecs[16] = mk(0, 0, 0,    0, 0,    0, 1, 1, 0, 0,    0);

        for (int i = 0; i < 17; i++) begin
            rst = vecs[i].rst;
            drive(vecs[i].r0, int'(vecs[i].c0), vecs[i].l0,
                  vecs[i].r1, int'(vecs[i].c1), vecs[i].l1, vecs[i].cons);
            half_check();
            chk($sformatf("vec%0d_can0", i), rq0_canReceive, vecs[i].e_can0);
            chk($sformatf("vec%0d_can1", i), rq1_canReceive, vecs[i].e_can1);
            chk($sformatf("vec%0d_has", i), cmd_hasAny, vecs[i].e_has);
            chk($sformatf("vec%0d_cmd", i), cmd, vecs[i].e_cmd);
            chk($sformatf("vec%0d_grant", i), grant, vecs[i].e_grant);
            half_edge();
        end
        exp_q = '{'h15, 'h31, 'h32, 'h33, 'h34};
        chk_order("table_order");

        // Alternation: three unlocked commands per requester, consume held high.
        for (int i = 0; i < 3; i++) begin
            drive(1, 'hA0 + i, 0, 1, 'hB0 + i, 0, 1);
            cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) cycle();
        exp_q = '{'hA0, 'hB0, 'hA1, 'hB1, 'hA2, 'hB2};
        chk_order("alternation");

        // Lock hold: A(lock) on rq0, C on rq1, B(unlocked) on rq0 five cycles after A.
        drive(1, 'h0A, 1, 1, 'h0C, 0, 1);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 2; i <= 6; i++) begin
            if (i == 6) drive(1, 'h0B, 0, 0, 0, 0, 1);
            half_check();
            if (i >= 4) begin
                chk("lock_gap_grant", grant, 2'b01);
                chk("lock_gap_has", cmd_hasAny, 1'b0);
            end
            half_edge();
            drive(0, 0, 0, 0, 0, 0, 1);
        end
        for (int i = 0; i < 4; i++) cycle();
        exp_q = '{'h0A, 'h0B, 'h0C};
        chk_order("lock_order");

        // Reset mid-stream while GRANT1 holds two entries and rr favours rq1.
        drive(1, 'h11, 0, 1, 'h21, 0, 0);
        cycle();
        drive(0, 0, 0, 1, 'h22, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 1);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        half_check();
        chk("pre_rst_grant", grant, 2'b10);
        half_edge();
        rst = 1'b1;
        drive(1, 'h3F, 0, 1, 'h3E, 0, 1);
        half_check();
        chk("in_rst_has", cmd_hasAny, 1'b0);
        chk("in_rst_can1", rq1_canReceive, 1'b1);
        half_edge();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        half_check();
        chk("post_rst_grant", grant, 2'b00);
        chk("post_rst_has", cmd_hasAny, 1'b0);
        chk("post_rst_cmd", cmd, '0);
        chk("post_rst_can1", rq1_canReceive, 1'b1);
        half_edge();
        drive(1, 'h12, 0, 1, 'h23, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();
        half_check();
        chk("tie_after_rst_grant", grant, 2'b01);
        chk("tie_after_rst_cmd", cmd, 'h12);
        half_edge();
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle();
        exp_q = '{'h11, 'h12, 'h23};
        chk_order("rst_order");

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) != 0);
            cycle();
        end
        rst = 1'b0;
        got.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
